// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared state type and default sizing for the register dump reader
package reg_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_OUT,
        ST_FIN
    } state_t;

    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_WIDTH    = 16;

endpackage

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks an external register file and streams each entry out with a handshake
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Abort,
    output logic [2:0]       RD_SEL,
    input  logic [WIDTH-1:0] RD_DATA,
    output logic [WIDTH-1:0] Out_data,
    output logic [2:0]       Out_idx,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic             Busy,
    output logic             Done
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

    state_t     state;
    logic [2:0] idx;

    assign RD_SEL = idx;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            idx       <= 3'd0;
            Out_data  <= '0;
            Out_idx   <= 3'd0;
            Out_valid <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Start together with Abort is treated as no request.
                    if (Start && !Abort) begin
                        state <= ST_ADDR;
                        idx   <= 3'd0;
                        Busy  <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (Abort) begin
                        state <= ST_IDLE;
                        idx   <= 3'd0;
                        Busy  <= 1'b0;
                    end else begin
                        Out_data  <= RD_DATA;
                        Out_idx   <= idx;
                        Out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    // Abort wins over a handshake arriving on the same edge.
                    if (Abort) begin
                        state     <= ST_IDLE;
                        idx       <= 3'd0;
                        Out_valid <= 1'b0;
                        Busy      <= 1'b0;
                    end else if (Out_ready) begin
                        Out_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= ST_FIN;
                            Done  <= 1'b1;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= ST_ADDR;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    idx   <= 3'd0;
                    Busy  <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    idx       <= 3'd0;
                    Out_valid <= 1'b0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - randomized self-checking bench for reg_dump_reader
module tb_reg_dump_reader;

    localparam int NR = 8;
    localparam int W  = 16;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Start = 1'b0;
    logic         Abort = 1'b0;
    logic [2:0]   RD_SEL;
    logic [W-1:0] RD_DATA;
    logic [W-1:0] Out_data;
    logic [2:0]   Out_idx;
    logic         Out_valid;
    logic         Out_ready = 1'b0;
    logic         Busy;
    logic         Done;

    logic [W-1:0] regs [NR];
    int checks = 0;
    int errors = 0;

    assign RD_DATA = regs[RD_SEL];

    always #5 Clk = ~Clk;

    reg_dump_reader #(.NUM_REGS(NR), .WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .RD_SEL(RD_SEL), .RD_DATA(RD_DATA),
        .Out_data(Out_data), .Out_idx(Out_idx), .Out_valid(Out_valid),
        .Out_ready(Out_ready), .Busy(Busy), .Done(Done)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_counting();
        for (int i = 0; i < NR; i++) regs[i] = 16'h1000 + 16'(i);
    endtask

    task automatic test_reset();
        load_counting();
        #3;
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", Out_valid); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
        checks++; if (RD_SEL !== 3'd0) begin errors++; $display("FAIL reset_rdsel got %0d want 0", RD_SEL); end
        checks++; if (Out_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", Out_data); end
        checks++; if (Out_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", Out_idx); end
        tick();
        Reset = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL first_start busy got %b want 1", Busy); end
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_addr busy got %b want 0", Busy); end
    endtask

    task automatic test_basic_dump();
        int n = 0, done_cnt = 0, first_valid = -1, done_at = -1, idle_at = -1;
        load_counting();
        Out_ready = 1'b1;
        Start = 1'b1;
        for (int t = 1; t <= 40 && idle_at < 0; t++) begin
            tick();
            Start = 1'b0;
            if (Busy && !Out_valid && !Done) begin
                checks++; if (RD_SEL !== 3'(n)) begin errors++; $display("FAIL basic_rdsel got %0d want %0d", RD_SEL, n); end
            end
            if (Out_valid) begin
                if (first_valid < 0) first_valid = t;
                checks++; if (Out_idx !== 3'(n)) begin errors++; $display("FAIL basic_idx got %0d want %0d", Out_idx, n); end
                checks++; if (Out_data !== 16'h1000 + 16'(n)) begin errors++; $display("FAIL basic_data got %h want %h", Out_data, 16'h1000 + 16'(n)); end
                n++;
            end
            if (Done) begin done_cnt++; done_at = t; end
            if (!Busy) idle_at = t;
        end
        checks++; if (n != NR) begin errors++; $display("FAIL basic_count got %0d want %0d", n, NR); end
        checks++; if (first_valid != 2) begin errors++; $display("FAIL basic_latency got %0d want 2", first_valid); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
        checks++; if (done_at != 2 * NR + 1) begin errors++; $display("FAIL basic_done_at got %0d want %0d", done_at, 2 * NR + 1); end
        checks++; if (idle_at != 2 * NR + 2) begin errors++; $display("FAIL basic_total got %0d want %0d", idle_at, 2 * NR + 2); end
    endtask

    task automatic test_stall();
        int n = 0, stall = 0, guard = 0;
        load_counting();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        while (Busy && guard < 100) begin
            guard++;
            if (Out_valid && Out_idx == 3'd3 && stall < 5) begin
                Out_ready = 1'b0;
                checks++; if (Out_data !== 16'h1003 || Out_idx !== 3'd3) begin errors++; $display("FAIL stall_hold got %h/%0d want 1003/3", Out_data, Out_idx); end
                stall++;
            end else begin
                Out_ready = 1'b1;
            end
            if (Out_valid && Out_ready) begin
                checks++; if (Out_idx !== 3'(n) || Out_data !== 16'h1000 + 16'(n)) begin errors++; $display("FAIL stall_item got %0d/%h want %0d", Out_idx, Out_data, n); end
                n++;
            end
            tick();
        end
        Out_ready = 1'b1;
        checks++; if (guard >= 100) begin errors++; $display("FAIL stall_timeout got %0d cycles want <100", guard); end
        checks++; if (n != NR) begin errors++; $display("FAIL stall_count got %0d want %0d", n, NR); end
        checks++; if (stall != 5) begin errors++; $display("FAIL stall_cycles got %0d want 5", stall); end
    endtask

    task automatic test_abort();
        int guard = 0, done_cnt = 0, stray = 0;
        bit hit = 0;
        load_counting();
        Out_ready = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        while (!hit && guard < 60) begin
            guard++;
            if (Done) done_cnt++;
            if (Out_valid && Out_idx == 3'd4) begin
                hit = 1;
                Abort = 1'b1;
            end
            tick();
        end
        Abort = 1'b0;
        checks++; if (!hit) begin errors++; $display("FAIL abort_reach got %0d want 1", hit); end
        checks++; if (Out_valid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL abort_state got valid=%b busy=%b want 0/0", Out_valid, Busy); end
        checks++; if (RD_SEL !== 3'd0) begin errors++; $display("FAIL abort_rdsel got %0d want 0", RD_SEL); end
        for (int t = 0; t < 6; t++) begin
            if (Done) done_cnt++;
            if (Out_valid || Busy) stray++;
            tick();
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt); end
        checks++; if (stray != 0) begin errors++; $display("FAIL abort_stray got %0d want 0", stray); end
    endtask

    task automatic test_restart_ignored();
        int n = 0, done_cnt = 0, guard = 0, stray = 0;
        bit pulsed = 0;
        load_counting();
        Out_ready = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        while (Busy && guard < 60) begin
            guard++;
            Start = (!pulsed && Out_valid && Out_idx == 3'd2);
            if (Start) pulsed = 1;
            if (Out_valid) begin
                checks++; if (Out_idx !== 3'(n)) begin errors++; $display("FAIL restart_idx got %0d want %0d", Out_idx, n); end
                n++;
            end
            if (Done) done_cnt++;
            tick();
        end
        Start = 1'b0;
        for (int t = 0; t < 4; t++) begin
            if (Busy || Out_valid) stray++;
            tick();
        end
        checks++; if (n != NR) begin errors++; $display("FAIL restart_count got %0d want %0d", n, NR); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done got %0d want 1", done_cnt); end
        checks++; if (stray != 0) begin errors++; $display("FAIL restart_queued got %0d want 0", stray); end
    endtask

    task automatic test_async_reset();
        int guard = 0, stray = 0, n = 0;
        bit hit = 0;
        load_counting();
        Out_ready = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        while (!hit && guard < 60) begin
            guard++;
            if (Out_valid && Out_idx == 3'd5) hit = 1;
            else tick();
        end
        #2 Reset = 1'b0;
        #1;
        checks++; if (!hit) begin errors++; $display("FAIL areset_reach got %0d want 1", hit); end
        checks++; if ({RD_SEL, Out_data, Out_idx, Out_valid, Busy, Done} !== '0) begin
            errors++; $display("FAIL areset_outputs got sel=%0d data=%h idx=%0d v=%b b=%b d=%b want all 0", RD_SEL, Out_data, Out_idx, Out_valid, Busy, Done);
        end
        tick();
        Reset = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (Out_valid || Busy) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL areset_stray got %0d want 0", stray); end
        Start = 1'b1;
        tick();
        Start = 1'b0;
        guard = 0;
        while (Busy && guard < 60) begin
            guard++;
            if (Out_valid) begin
                checks++; if (Out_idx !== 3'(n)) begin errors++; $display("FAIL areset_redump_idx got %0d want %0d", Out_idx, n); end
                n++;
            end
            tick();
        end
        checks++; if (n != NR) begin errors++; $display("FAIL areset_redump_count got %0d want %0d", n, NR); end
    endtask

    task automatic test_data_hold();
        int hold = 0, guard = 0, n = 0;
        load_counting();
        regs[6] = 16'hBEEF;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        while (Busy && guard < 60) begin
            guard++;
            if (Out_valid && Out_idx == 3'd6 && hold < 4) begin
                Out_ready = 1'b0;
                if (hold == 0) regs[6] = 16'hCAFE;
                checks++; if (Out_data !== 16'hBEEF) begin errors++; $display("FAIL hold_data got %h want beef", Out_data); end
                hold++;
            end else begin
                Out_ready = 1'b1;
            end
            if (Out_valid && Out_ready) n++;
            tick();
        end
        Out_ready = 1'b1;
        checks++; if (hold != 4 || n != NR) begin errors++; $display("FAIL hold_run got hold=%0d items=%0d want 4/%0d", hold, n, NR); end
    endtask

    // Reference: item i carries regs[i] as they stood at Start; Done follows the last acceptance by one cycle.
    task automatic test_random();
        logic [W-1:0] exp_q [$];
        for (int run = 0; run < 6; run++) begin
            int guard = 0, n = 0, done_cnt = 0;
            bit last_acc = 0, pend = 0;
            logic [W-1:0] pd;
            logic [2:0] pi;
            exp_q.delete();
            for (int i = 0; i < NR; i++) begin
                regs[i] = 16'($urandom);
                exp_q.push_back(regs[i]);
            end
            Start = 1'b1;
            tick();
            Start = 1'b0;
            while (Busy && guard < 200) begin
                guard++;
                checks++; if (Done !== last_acc) begin errors++; $display("FAIL rand_done got %b want %b", Done, last_acc); end
                if (Done) done_cnt++;
                if (pend) begin
                    checks++; if (Out_valid !== 1'b1 || Out_data !== pd || Out_idx !== pi) begin
                        errors++; $display("FAIL rand_stable got %b/%h/%0d want 1/%h/%0d", Out_valid, Out_data, Out_idx, pd, pi);
                    end
                end
                Out_ready = 1'($urandom_range(0, 1));
                Start = Out_valid && ($urandom_range(0, 3) == 0);
                last_acc = 0;
                pend = Out_valid && !Out_ready;
                pd = Out_data;
                pi = Out_idx;
                if (Out_valid && Out_ready) begin
                    checks++; if (Out_idx !== 3'(n) || Out_data !== exp_q[0]) begin
                        errors++; $display("FAIL rand_item got %0d/%h want %0d/%h", Out_idx, Out_data, n, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                    n++;
                    last_acc = (n == NR);
                end
                tick();
            end
            Start = 1'b0;
            Out_ready = 1'b1;
            checks++; if (n != NR || done_cnt != 1) begin errors++; $display("FAIL rand_run%0d got items=%0d done=%0d want %0d/1", run, n, done_cnt, NR); end
        end
    endtask

    task automatic test_start_abort_idle();
        Start = 1'b1;
        Abort = 1'b1;
        tick();
        Start = 1'b0;
        Abort = 1'b0;
        checks++; if (Busy !== 1'b0 || Out_valid !== 1'b0) begin errors++; $display("FAIL start_abort got busy=%b valid=%b want 0/0", Busy, Out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_dump();
        test_stall();
        test_abort();
        test_restart_ignored();
        test_async_reset();
        test_data_hold();
        test_random();
        test_start_abort_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter NUM_REGS, default 8, number of register-file entries to read (power of two, 2..8).
REQ-002 Parameter WIDTH, default 16, register data width.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, independent of Clk.
REQ-005 Start  input  1  request one full dump; sampled only in IDLE.
REQ-006 Abort  input  1  terminate an in-progress dump.
REQ-007 RD_SEL  output  3  read-port address driven to register-file source-select input.
REQ-008 RD_DATA  input  WIDTH  combinational read data returned for RD_SEL in the same cycle.
REQ-009 Out_data  output  WIDTH  captured register value.
REQ-010 Out_idx  output  3  register index of Out_data.
REQ-011 Out_valid  output  1  Out_data/Out_idx valid.
REQ-012 Out_ready  input  1  consumer accepts current item.
REQ-013 Busy  output  1  high in every state except IDLE.
REQ-014 Done  output  1  one-cycle pulse after last item accepted.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, OUT, FIN.
REQ-016 IDLE: Start=1 -> ADDR with index counter cleared to 0; otherwise remain.
REQ-017 ADDR: RD_SEL = index; at clock edge RD_DATA captured into Out_data, index into Out_idx; -> OUT.
REQ-018 OUT: Out_valid=1; Out_data and Out_idx SHALL hold stable until Out_ready=1 at an edge.
REQ-019 OUT with Out_ready=1 and index < NUM_REGS-1: index increments by 1, -> ADDR.
REQ-020 OUT with Out_ready=1 and index = NUM_REGS-1: -> FIN; index does not wrap past NUM_REGS-1.
REQ-021 FIN: Done=1 for exactly one cycle, -> IDLE.
REQ-022 Latency: Start sampled at edge N -> Out_valid high in cycle after edge N+1; minimum dump = 2*NUM_REGS+2 cycles with Out_ready tied high.
REQ-023 Start while Busy=1 SHALL be ignored (no restart, no queueing).
REQ-024 Abort=1 in ADDR or OUT -> IDLE next edge, Out_valid deasserts, Done not pulsed; Abort takes priority over a simultaneous Out_ready handshake.
REQ-025 Abort in IDLE or FIN has no effect; Start and Abort together in IDLE -> remain IDLE.
REQ-026 RD_SEL SHALL equal index in all states (0 in IDLE).
REQ-027 Out_valid SHALL be 1 only in OUT; Done only in FIN.

Reset
REQ-028 Reset=0 -> state IDLE, index 0, RD_SEL 0, Out_data 0, Out_idx 0, Out_valid 0, Busy 0, Done 0.
REQ-029 Reset asserted mid-dump SHALL discard the dump; after release no item is emitted until a new Start.
REQ-030 First Start is honoured on the first rising edge after Reset deasserts.

Structure
REQ-031 Package reg_dump_pkg SHALL hold the state enum type and the default NUM_REGS/WIDTH constants.
REQ-032 Single module; no sub-module; register file is external and connected via RD_SEL/RD_DATA.

Verification
REQ-033 Model file R0..R7 = 16'h1000+i, Out_ready=1, pulse Start -> 8 items idx 0..7 data 16'h1000..16'h1007 in order, Done pulse once, total 18 cycles.
REQ-034 Out_ready low 5 cycles while item idx 3 valid -> Out_data 16'h1003, Out_idx 3 held stable all 5 cycles, no skip or duplicate.
REQ-035 Abort asserted with item idx 4 valid and Out_ready=1 -> IDLE next cycle, Out_valid 0, Done never pulses, Busy 0.
REQ-036 Start re-pulsed during dump at idx 2 -> sequence continues 3..7 unchanged, exactly one Done.
REQ-037 Reset=0 asynchronously between edges during idx 5 -> all outputs 0 immediately; after release no Out_valid until new Start, then full dump from idx 0.
REQ-038 Register file value changed (R6 16'hBEEF -> 16'hCAFE) while idx 6 item waits for Out_ready -> Out_data remains 16'hBEEF.
